// File: rtl/fft_addr_gen.sv
// fft_addr_gen
// Control sequencer for an in-place radix-2 DIF FFT. For each stage it issues
// one butterfly per cycle: an operand address pair plus a twiddle ROM index.
// The matching write-back addresses come out PIPE_LAT cycles later. A
// PIPE_LAT-cycle drain gap separates stages, so the next stage never reads a
// location that the previous stage has not yet written.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   start      begin a transform (sampled only in IDLE)
//   stall      hold issue while in RUN
//   busy       high while a transform is in progress
//   done       one-cycle pulse after the final write-back
//   stage      current stage index 0..LOG2N-1
//   rd_en      one butterfly issued this cycle
//   rd_addr_a  top operand address
//   rd_addr_b  bottom operand address
//   tw_idx     twiddle ROM index, valid with rd_en
//   wr_en      write-back strobe (rd_en delayed by PIPE_LAT)
//   wr_addr_a  write address for the top result
//   wr_addr_b  write address for the bottom result
module fft_addr_gen #(
  parameter int LOG2N    = 4,
  parameter int PIPE_LAT = 3,
  parameter int STG_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  output logic             busy,
  output logic             done,
  output logic [STG_W-1:0] stage,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
);
  localparam int B_W  = LOG2N - 1;
  localparam int FC_W = $clog2(PIPE_LAT + 1);
  localparam logic [B_W-1:0]   B_LAST  = '1;
  localparam logic [STG_W-1:0] S_LAST  = STG_W'(LOG2N - 1);
  localparam logic [FC_W-1:0]  FC_LAST = FC_W'(PIPE_LAT);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t           state_q, state_d;
  logic [STG_W-1:0] s_d;
  logic [B_W-1:0]   b_q, b_d;
  logic [FC_W-1:0]  fc_q, fc_d;
  logic             issue, busy_d, done_d;
  logic [LOG2N-1:0] nxt_a, nxt_b;
  logic [B_W-1:0]   nxt_tw;

  // Distance between the two operands of a butterfly in stage s: N >> (s+1).
  function automatic logic [LOG2N-1:0] span_of(input logic [STG_W-1:0] s);
    return LOG2N'(1) << (LOG2N - 1 - int'(s));
  endfunction

  // Top operand: group index moved above the span bits, position kept below.
  function automatic logic [LOG2N-1:0] addr_top(input logic [STG_W-1:0] s,
                                                input logic [B_W-1:0]   b);
    logic [LOG2N-1:0] bx, pos, grp;
    bx  = {1'b0, b};
    pos = bx & (span_of(s) - LOG2N'(1));
    grp = bx >> (LOG2N - 1 - int'(s));
    return (grp << (LOG2N - int'(s))) | pos;
  endfunction

  // Twiddle index: position within the group scaled by 2**s. For s = 0 the
  // mask shift overflows to zero, so the mask wraps to all ones.
  function automatic logic [B_W-1:0] tw_of(input logic [STG_W-1:0] s,
                                           input logic [B_W-1:0]   b);
    logic [B_W-1:0] mask;
    mask = (B_W'(1) << (LOG2N - 1 - int'(s))) - B_W'(1);
    return (b & mask) << s;
  endfunction

  // The registered outputs describe the current cycle. The next-state logic
  // therefore decides what the next cycle presents; accepting start or
  // leaving FLUSH issues butterfly 0 straight away.
  always_comb begin
    state_d = state_q;
    s_d     = stage;
    b_d     = b_q;
    fc_d    = fc_q;
    issue   = 1'b0;
    busy_d  = busy;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          s_d     = '0;
          b_d     = '0;
          issue   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (b_q == B_LAST) begin
          state_d = FLUSH;
          fc_d    = FC_W'(1);
        end else if (!stall) begin
          b_d   = b_q + B_W'(1);
          issue = 1'b1;
        end
      end
      FLUSH: begin
        if (fc_q == FC_LAST) begin
          if (stage == S_LAST) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            s_d     = stage + STG_W'(1);
            b_d     = '0;
            issue   = 1'b1;
          end
        end else begin
          fc_d = fc_q + FC_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    nxt_a  = addr_top(s_d, b_d);
    nxt_b  = nxt_a + span_of(s_d);
    nxt_tw = tw_of(s_d, b_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      stage     <= '0;
      b_q       <= '0;
      fc_q      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_idx    <= '0;
    end else begin
      state_q <= state_d;
      stage   <= s_d;
      b_q     <= b_d;
      fc_q    <= fc_d;
      busy    <= busy_d;
      done    <= done_d;
      rd_en   <= issue;
      // Addresses hold while no butterfly is issued (stall, flush, idle).
      if (issue) begin
        rd_addr_a <= nxt_a;
        rd_addr_b <= nxt_b;
        tw_idx    <= nxt_tw;
      end
    end
  end

  // Write-back delay line: stage 0 captures the read side, and the last
  // stage drives the write port. It shifts every cycle regardless of stall.
  logic             vld_p [PIPE_LAT];
  logic [LOG2N-1:0] wa_p  [PIPE_LAT];
  logic [LOG2N-1:0] wb_p  [PIPE_LAT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        vld_p[i] <= 1'b0;
        wa_p[i]  <= '0;
        wb_p[i]  <= '0;
      end
    end else begin
      vld_p[0] <= rd_en;
      wa_p[0]  <= rd_addr_a;
      wb_p[0]  <= rd_addr_b;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        wa_p[i]  <= wa_p[i-1];
        wb_p[i]  <= wb_p[i-1];
      end
    end
  end

  assign wr_en     = vld_p[PIPE_LAT-1];
  assign wr_addr_a = wa_p[PIPE_LAT-1];
  assign wr_addr_b = wb_p[PIPE_LAT-1];

endmodule

// File: tb/tb_fft_addr_gen.sv
// Testbench for fft_addr_gen. Instance u0 uses LOG2N=4, PIPE_LAT=3 and
// instance u1 uses LOG2N=3, PIPE_LAT=1. Stimulus pushes the expected read,
// write and done events, each tagged with its cycle, and monitors pop them
// whenever a DUT strobe appears.
module tb_fft_addr_gen;
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst0, rst1, start0, start1, stall0, stall1;
  logic       busy0, done0, rd_en0, wr_en0;
  logic [3:0] stage0, ra0, rb0, wa0, wb0;
  logic [2:0] tw0;
  logic       busy1, done1, rd_en1, wr_en1;
  logic [3:0] stage1;
  logic [2:0] ra1, rb1, wa1, wb1;
  logic [1:0] tw1;

  fft_addr_gen #(.LOG2N(4), .PIPE_LAT(3), .STG_W(4)) u0 (
    .clk(clk), .reset(rst0), .start(start0), .stall(stall0),
    .busy(busy0), .done(done0), .stage(stage0), .rd_en(rd_en0),
    .rd_addr_a(ra0), .rd_addr_b(rb0), .tw_idx(tw0),
    .wr_en(wr_en0), .wr_addr_a(wa0), .wr_addr_b(wb0));

  fft_addr_gen #(.LOG2N(3), .PIPE_LAT(1), .STG_W(4)) u1 (
    .clk(clk), .reset(rst1), .start(start1), .stall(stall1),
    .busy(busy1), .done(done1), .stage(stage1), .rd_en(rd_en1),
    .rd_addr_a(ra1), .rd_addr_b(rb1), .tw_idx(tw1),
    .wr_en(wr_en1), .wr_addr_a(wa1), .wr_addr_b(wb1));

  typedef struct {int cyc; int st; int a; int b; int tw;} ev_t;

  ev_t rdq0[$], wrq0[$], rdq1[$], wrq1[$];
  int  dq0[$], dq1[$];
  int  n_tests = 0, n_fail = 0;
  int  rdc0 = 0, wrc0 = 0, rdc1 = 0, wrc1 = 0;
  int  blo0 = 1, bhi0 = 0, blo1 = 1, bhi1 = 0;

  int exp_a1[4] = '{0, 1, 4, 5};
  int exp_b1[4] = '{2, 3, 6, 7};
  int exp_t1[4] = '{0, 2, 0, 2};

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected events come from a group/position enumeration of the butterflies.
  task automatic push_run(input int id, input int t0, input int sst, input int sb,
                          input int slen, input int done_at);
    int lg, pl, n, c, span, bi;
    ev_t e, w;
    lg = (id == 0) ? 4 : 3;
    pl = (id == 0) ? 3 : 1;
    n  = 1 << lg;
    c  = t0 + 1;
    for (int s = 0; s < lg; s++) begin
      span = n >> (s + 1);
      bi   = 0;
      for (int g = 0; g < (1 << s); g++) begin
        for (int p = 0; p < span; p++) begin
          e.cyc = c; e.st = s; e.a = g * 2 * span + p; e.b = e.a + span; e.tw = p * (1 << s);
          w = e; w.cyc = c + pl; w.st = 0; w.tw = 0;
          if (id == 0) begin rdq0.push_back(e); wrq0.push_back(w); end
          else begin rdq1.push_back(e); wrq1.push_back(w); end
          c++;
          if (s == sst && bi == sb) c += slen;
          bi++;
        end
      end
      c += pl;
    end
    if (id == 0) begin dq0.push_back(done_at); blo0 = t0 + 1; bhi0 = done_at - 1; rdc0 = 0; wrc0 = 0; end
    else begin dq1.push_back(done_at); blo1 = t0 + 1; bhi1 = done_at - 1; rdc1 = 0; wrc1 = 0; end
  endtask

  task automatic got_rd(input int id, input int st, input int a, input int b, input int tw);
    ev_t e;
    bit  have;
    have = 1'b0;
    n_tests++;
    if (id == 0 && rdq0.size() > 0) begin e = rdq0.pop_front(); have = 1'b1; end
    if (id == 1 && rdq1.size() > 0) begin e = rdq1.pop_front(); have = 1'b1; end
    if (!have) begin
      n_fail++;
      $display("FAIL u%0d read unexpected at cycle %0d: got (%0d,%0d) tw %0d, required no read",
               id, cyc, a, b, tw);
    end else if (e.cyc != cyc || e.st != st || e.a != a || e.b != b || e.tw != tw) begin
      n_fail++;
      $display("FAIL u%0d read: got cycle %0d stage %0d (%0d,%0d) tw %0d, required cycle %0d stage %0d (%0d,%0d) tw %0d",
               id, cyc, st, a, b, tw, e.cyc, e.st, e.a, e.b, e.tw);
    end
  endtask

  task automatic got_wr(input int id, input int a, input int b);
    ev_t e;
    bit  have;
    have = 1'b0;
    n_tests++;
    if (id == 0 && wrq0.size() > 0) begin e = wrq0.pop_front(); have = 1'b1; end
    if (id == 1 && wrq1.size() > 0) begin e = wrq1.pop_front(); have = 1'b1; end
    if (!have) begin
      n_fail++;
      $display("FAIL u%0d write unexpected at cycle %0d: got (%0d,%0d), required no write", id, cyc, a, b);
    end else if (e.cyc != cyc || e.a != a || e.b != b) begin
      n_fail++;
      $display("FAIL u%0d write: got cycle %0d (%0d,%0d), required cycle %0d (%0d,%0d)",
               id, cyc, a, b, e.cyc, e.a, e.b);
    end
  endtask

  task automatic got_done(input int id);
    int  d;
    bit  have;
    have = 1'b0;
    d    = 0;
    n_tests++;
    if (id == 0 && dq0.size() > 0) begin d = dq0.pop_front(); have = 1'b1; end
    if (id == 1 && dq1.size() > 0) begin d = dq1.pop_front(); have = 1'b1; end
    if (!have) begin
      n_fail++;
      $display("FAIL u%0d done unexpected at cycle %0d, required none", id, cyc);
    end else if (d != cyc) begin
      n_fail++;
      $display("FAIL u%0d done: got cycle %0d, required cycle %0d", id, cyc, d);
    end
  endtask

  task automatic end_run(input int id, input int cnt);
    if (id == 0) begin
      chk("u0 rd_en total", rdc0, cnt);
      chk("u0 wr_en total", wrc0, cnt);
      chk("u0 reads left", rdq0.size(), 0);
      chk("u0 writes left", wrq0.size(), 0);
    end else begin
      chk("u1 rd_en total", rdc1, cnt);
      chk("u1 wr_en total", wrc1, cnt);
      chk("u1 reads left", rdq1.size(), 0);
      chk("u1 writes left", wrq1.size(), 0);
    end
  endtask

  // Monitors
  always @(negedge clk) begin
    if (rd_en0 === 1'b1) begin
      rdc0++;
      got_rd(0, int'(stage0), int'(ra0), int'(rb0), int'(tw0));
    end
    if (wr_en0 === 1'b1) begin
      wrc0++;
      got_wr(0, int'(wa0), int'(wb0));
    end
    if (done0 === 1'b1) got_done(0);
    chk("u0 busy", int'(busy0), (cyc >= blo0 && cyc <= bhi0) ? 1 : 0);
    if (rd_en1 === 1'b1) begin
      rdc1++;
      got_rd(1, int'(stage1), int'(ra1), int'(rb1), int'(tw1));
    end
    if (wr_en1 === 1'b1) begin
      wrc1++;
      got_wr(1, int'(wa1), int'(wb1));
    end
    if (done1 === 1'b1) got_done(1);
    chk("u1 busy", int'(busy1), (cyc >= blo1 && cyc <= bhi1) ? 1 : 0);
  end

  initial begin
    rst0 = 1'b0; rst1 = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    stall0 = 1'b0; stall1 = 1'b0;
    goto(2);
    chk("u0 reset rd_en", int'(rd_en0), 0);
    chk("u0 reset wr_en", int'(wr_en0), 0);
    chk("u0 reset busy", int'(busy0), 0);
    chk("u0 reset done", int'(done0), 0);
    chk("u0 reset rd_addr_a", int'(ra0), 0);
    chk("u0 reset rd_addr_b", int'(rb0), 0);
    chk("u0 reset stage", int'(stage0), 0);
    chk("u1 reset rd_en", int'(rd_en1), 0);
    chk("u1 reset wr_en", int'(wr_en1), 0);
    chk("u1 reset busy", int'(busy1), 0);
    rst0 = 1'b1; rst1 = 1'b1;

    // Basic run on u0, start accepted at cycle 5, done at 5+45.
    goto(5);
    push_run(0, 5, -1, 0, 0, 50);
    start0 = 1'b1;
    goto(6);
    start0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      goto(6 + k);
      chk("u0 s0 rd_en", int'(rd_en0), 1);
      chk("u0 s0 rd_addr_a", int'(ra0), k);
      chk("u0 s0 rd_addr_b", int'(rb0), k + 8);
      chk("u0 s0 tw_idx", int'(tw0), k);
    end
    goto(15);
    start0 = 1'b1;                      // while busy: ignored
    goto(16);
    start0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      goto(39 + k);
      chk("u0 s3 stage", int'(stage0), 3);
      chk("u0 s3 rd_addr_a", int'(ra0), 2 * k);
      chk("u0 s3 rd_addr_b", int'(rb0), 2 * k + 1);
      chk("u0 s3 tw_idx", int'(tw0), 0);
    end

    // start in the DONE cycle is ignored; start in the following IDLE cycle
    // (51) launches a run with a 3-cycle stall at stage 1, b=2. Done at 51+48.
    goto(50);
    end_run(0, 32);
    push_run(0, 51, 1, 2, 3, 99);
    start0 = 1'b1;
    goto(52);
    start0 = 1'b0;
    goto(65);
    stall0 = 1'b1;
    goto(66);
    chk("u0 stall rd_en", int'(rd_en0), 0);
    chk("u0 stall hold a", int'(ra0), 2);
    chk("u0 stall hold b", int'(rb0), 6);
    goto(67);
    chk("u0 stall rd_en", int'(rd_en0), 0);
    chk("u0 stall hold a", int'(ra0), 2);
    chk("u0 stall hold b", int'(rb0), 6);
    goto(68);
    stall0 = 1'b0;
    goto(100);
    end_run(0, 32);

    // Reset in the middle of stage 2, then a complete fresh run.
    goto(102);
    push_run(0, 102, -1, 0, 0, 147);
    start0 = 1'b1;
    goto(103);
    start0 = 1'b0;
    goto(127);
    chk("u0 pre-reset stage", int'(stage0), 2);
    #1;
    rst0 = 1'b0;
    rdq0.delete(); wrq0.delete(); dq0.delete();
    blo0 = 1; bhi0 = 0;
    #1;
    chk("u0 mid reset rd_en", int'(rd_en0), 0);
    chk("u0 mid reset wr_en", int'(wr_en0), 0);
    chk("u0 mid reset busy", int'(busy0), 0);
    chk("u0 mid reset rd_addr_a", int'(ra0), 0);
    chk("u0 mid reset rd_addr_b", int'(rb0), 0);
    chk("u0 mid reset tw_idx", int'(tw0), 0);
    chk("u0 mid reset stage", int'(stage0), 0);
    chk("u0 mid reset wr_addr_a", int'(wa0), 0);
    goto(132);
    rst0 = 1'b1;
    goto(135);
    push_run(0, 135, -1, 0, 0, 180);
    start0 = 1'b1;
    goto(136);
    start0 = 1'b0;
    goto(181);
    end_run(0, 32);

    // u1: N=8, PIPE_LAT=1, start accepted at cycle 185, done at 185+16.
    goto(185);
    push_run(1, 185, -1, 0, 0, 201);
    start1 = 1'b1;
    goto(186);
    start1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      goto(191 + k);
      chk("u1 s1 stage", int'(stage1), 1);
      chk("u1 s1 rd_addr_a", int'(ra1), exp_a1[k]);
      chk("u1 s1 rd_addr_b", int'(rb1), exp_b1[k]);
      chk("u1 s1 tw_idx", int'(tw1), exp_t1[k]);
    end
    for (int k = 0; k < 4; k++) begin
      goto(196 + k);
      chk("u1 s2 rd_en", int'(rd_en1), 1);
      chk("u1 s2 tw_idx", int'(tw1), 0);
    end
    goto(203);
    end_run(1, 12);
    chk("u0 done left", dq0.size(), 0);
    chk("u1 done left", dq1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_addr_gen.md
Name: fft_addr_gen

Overview:
Parametrised control sequencer for an in-place radix-2 decimation-in-frequency (DIF) FFT over a single-port-pair butterfly datapath.
- Per stage, generates butterfly operand address pairs (read side) and twiddle ROM indices.
- Generates the matching write-back addresses after a fixed butterfly pipeline latency.
- Inserts a drain gap between stages so stage s+1 never reads data not yet written by stage s.
- Provides a start/busy/done handshake and an issue stall.
- Sits between the top-level FFT controller and the sample RAM, twiddle ROM and butterfly unit; replaces the fixed 16-point stage/address counter.

Parameters:
LOG2N, 4, log2 of FFT size N (N = 2**LOG2N); legal range 2..12.
PIPE_LAT, 3, butterfly latency in cycles from rd_en to matching wr_en; legal range 1..15.
STG_W, 4, width of stage output; must satisfy 2**STG_W > LOG2N - 1.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset.
start  input  1  begin a transform; sampled only in IDLE.
stall  input  1  hold issue; no read issued and counters frozen while high (RUN only).
busy  output  1  high from the cycle after start is accepted until done.
done  output  1  one-cycle pulse when the final write-back has completed.
stage  output  STG_W  current stage index 0..LOG2N-1.
rd_en  output  1  read/issue strobe for one butterfly.
rd_addr_a  output  LOG2N  top operand address.
rd_addr_b  output  LOG2N  bottom operand address.
tw_idx  output  LOG2N-1  twiddle ROM index, valid with rd_en.
wr_en  output  1  write-back strobe.
wr_addr_a  output  LOG2N  write address for top result.
wr_addr_b  output  LOG2N  write address for bottom result.

Behaviour:
- All outputs are registered.
- Reset (reset = 0), asynchronous: state = IDLE, all outputs 0, write-delay line cleared. No wr_en is emitted after reset, including for reads issued before reset.
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - start = 1 -> RUN, with butterfly counter b = 0 and stage s = 0.
  - busy = 1 from the next cycle.
- RUN:
  - stall = 0: rd_en = 1 and outputs for (s, b); b increments.
  - stall = 1: rd_en = 0; b and the address outputs hold.
  - After issuing b = N/2 - 1 -> FLUSH.
- FLUSH:
  - Lasts exactly PIPE_LAT cycles; stall is ignored.
  - Then -> RUN with s + 1 and b = 0, or -> DONE if s = LOG2N - 1.
- DONE:
  - done = 1 and busy = 0 for one cycle.
  - -> IDLE unconditionally; start in the DONE cycle is ignored.
- start while busy is ignored.
- Address arithmetic per issued butterfly:
  - span = N >> (s + 1); pos = b & (span - 1); grp = b >> (LOG2N - 1 - s).
  - rd_addr_a = (grp << (LOG2N - s)) | pos.
  - rd_addr_b = rd_addr_a + span.
  - tw_idx = pos << s, truncated to LOG2N-1 bits.
- Write side:
  - A PIPE_LAT-deep shift register carries {rd_en, rd_addr_a, rd_addr_b}.
  - wr_en and wr_addr_a/wr_addr_b equal the rd-side values of PIPE_LAT cycles earlier.
  - The write pipeline advances every cycle, stall or not.
- Timing:
  - The last write of a stage occurs in the final FLUSH cycle.
  - The next stage's first read occurs one cycle later (RAM write-then-read ordering assumed).
- Latency without stall, start accepted at cycle t:
  - first rd_en at t+1.
  - done at t+1+LOG2N*(N/2+PIPE_LAT).
  - Each stalled RUN cycle adds 1.
- Totals per transform: exactly LOG2N*N/2 rd_en pulses and LOG2N*N/2 wr_en pulses.

Test Plan:
1. Basic run (LOG2N=4, PIPE_LAT=3), start at t, no stall:
   - stage 0 pairs (0,8)..(7,15), tw 0..7.
   - stage 3 pairs (0,1),(2,3)..(14,15), tw 0.
   - done at t+45, single cycle; busy high t+1..t+44.
2. Write-back: each wr_en/wr_addr equals rd_en/rd_addr 3 cycles earlier; 32 wr_en total; none during the first 3 cycles of each stage.
3. Stall in stage 1 at b=2 for 3 cycles:
   - rd_en low and addresses (2,6) held.
   - Writes of earlier butterflies still emerge on time.
   - done at t+48.
4. Reset asserted mid-stage 2: all outputs 0 immediately; no wr_en afterwards. A new start after release runs a full transform from stage 0.
5. start pulsed while busy and in the DONE cycle -> ignored; start in the following IDLE cycle -> new run, first rd_en one cycle later.
6. LOG2N=3, PIPE_LAT=1:
   - stage 1 pairs (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2.
   - stage 2 tw all 0.
   - done at t+16.
